// File: rtl/dcache_ctrl.sv
// dcache_ctrl: direct-mapped, write-through, no-write-allocate byte cache controller.
// Latency: load hit 2 cycles; load miss N+3; store N+2 (N = memory ack delay in cycles).
// Backpressure: CpuReq is only sampled in IDLE (Busy=0) and is never queued; memory via MemReq/MemAck.
// Ports:
//   Clk, Reset              clock, synchronous active-high reset
//   CpuReq/Wr/Addr/WData    CPU byte request; CpuRData/CpuReady completion; Busy = not IDLE
//   RamAddr, Tag*/Valid*/Data*  shared index and ports of the tag, valid and data RAMs (registered reads)
//   RamInv                  one-cycle global invalidate of the tag and valid RAMs after reset
//   Mem*                    request/acknowledge memory port (reads on miss, every store written through)
module dcache_ctrl #(
  parameter int CACHESIZE = 1024,
  parameter int INDEX     = 10,
  parameter int TAG       = 6,
  localparam int ADDR     = TAG + INDEX
) (
  input  logic            Clk,
  input  logic            Reset,
  input  logic            CpuReq,
  input  logic            CpuWr,
  input  logic [ADDR-1:0] CpuAddr,
  input  logic [7:0]      CpuWData,
  output logic [7:0]      CpuRData,
  output logic            CpuReady,
  output logic            Busy,
  output logic [INDEX-1:0] RamAddr,
  output logic            TagWr,
  output logic [TAG-1:0]  TagIn,
  input  logic [TAG-1:0]  TagOut,
  output logic            ValidWr,
  output logic            ValidIn,
  input  logic            ValidOut,
  output logic            DataWr,
  output logic [7:0]      DataIn,
  input  logic [7:0]      DataOut,
  output logic            RamInv,
  output logic            MemReq,
  output logic            MemWr,
  output logic [ADDR-1:0] MemAddr,
  output logic [7:0]      MemWData,
  input  logic [7:0]      MemRData,
  input  logic            MemAck
);

  typedef enum logic [2:0] {
    S_INIT, S_IDLE, S_LOOKUP, S_MEMRD, S_FILL, S_MEMWR
  } state_t;

  state_t          state, state_nx;
  logic [ADDR-1:0] addr_q;
  logic [7:0]      wd_q;
  logic [7:0]      md_q;
  logic            wr_q;
  logic            hit;
  logic            ready_nx;
  logic            rdata_ld;
  logic [7:0]      rdata_nx;

  // CACHESIZE is 2**INDEX, so the modulo is simply the low INDEX address bits.
  function automatic logic [INDEX-1:0] idx_of(input logic [ADDR-1:0] a);
    return INDEX'(32'(a) % CACHESIZE);
  endfunction

  assign hit      = ValidOut & (TagOut == addr_q[ADDR-1:INDEX]);
  assign Busy     = (state != S_IDLE);
  // Request fields come straight from the captured registers, so they hold
  // steady for the whole MemReq window.
  assign MemAddr  = addr_q;
  assign MemWData = wd_q;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state    <= S_INIT;
      addr_q   <= '0;
      wd_q     <= '0;
      md_q     <= '0;
      wr_q     <= 1'b0;
      CpuReady <= 1'b0;
      CpuRData <= 8'h00;
    end else begin
      state    <= state_nx;
      CpuReady <= ready_nx;
      if (rdata_ld) CpuRData <= rdata_nx;
      if (state == S_IDLE && CpuReq) begin
        addr_q <= CpuAddr;
        wd_q   <= CpuWData;
        wr_q   <= CpuWr;
      end
      if (state == S_MEMRD && MemAck) md_q <= MemRData;
    end
  end

  // RAM strobes and RamInv are masked by Reset so that a reset arriving in
  // LOOKUP/FILL abandons the operation without touching the RAMs.
  always_comb begin
    state_nx = state;
    ready_nx = 1'b0;
    rdata_ld = 1'b0;
    rdata_nx = md_q;
    RamAddr  = idx_of(addr_q);
    TagWr    = 1'b0;
    TagIn    = addr_q[ADDR-1:INDEX];
    ValidWr  = 1'b0;
    ValidIn  = 1'b1;
    DataWr   = 1'b0;
    DataIn   = wd_q;
    RamInv   = 1'b0;
    MemReq   = 1'b0;
    MemWr    = 1'b0;
    case (state)
      S_INIT: begin
        RamInv   = ~Reset;
        state_nx = S_IDLE;
      end
      S_IDLE: begin
        // Present the incoming index so the RAMs read on the accepting edge.
        RamAddr = idx_of(CpuAddr);
        if (CpuReq) state_nx = S_LOOKUP;
      end
      S_LOOKUP: begin
        if (wr_q) begin
          DataWr   = hit & ~Reset;
          state_nx = S_MEMWR;
        end else if (hit) begin
          rdata_ld = 1'b1;
          rdata_nx = DataOut;
          ready_nx = 1'b1;
          state_nx = S_IDLE;
        end else begin
          state_nx = S_MEMRD;
        end
      end
      S_MEMRD: begin
        MemReq = 1'b1;
        if (MemAck) state_nx = S_FILL;
      end
      S_FILL: begin
        TagWr    = ~Reset;
        ValidWr  = ~Reset;
        DataWr   = ~Reset;
        DataIn   = md_q;
        rdata_ld = 1'b1;
        ready_nx = 1'b1;
        state_nx = S_IDLE;
      end
      S_MEMWR: begin
        MemReq = 1'b1;
        MemWr  = 1'b1;
        if (MemAck) begin
          ready_nx = 1'b1;
          state_nx = S_IDLE;
        end
      end
      default: state_nx = S_INIT;
    endcase
  end

endmodule

// File: tb/tb_dcache_ctrl.sv
// tb_dcache_ctrl: directed and random loads/stores against dcache_ctrl with RAM and memory models.
// Expected values come from a cache-level reference model (valid/tag per index plus a backing byte array).
// Memory acknowledge delay is programmable per transaction; stray acknowledges can be injected.
module tb_dcache_ctrl;
  localparam int INDEX = 10;
  localparam int TAG   = 6;
  localparam int ADDR  = 16;
  localparam int CS    = 1024;

  logic Clk = 1'b0;
  logic Reset;
  logic CpuReq, CpuWr;
  logic [ADDR-1:0] CpuAddr;
  logic [7:0] CpuWData, CpuRData;
  logic CpuReady, Busy;
  logic [INDEX-1:0] RamAddr;
  logic TagWr, ValidWr, ValidIn, ValidOut, DataWr, RamInv;
  logic [TAG-1:0] TagIn, TagOut;
  logic [7:0] DataIn, DataOut;
  logic MemReq, MemWr, MemAck;
  logic [ADDR-1:0] MemAddr;
  logic [7:0] MemWData, MemRData;

  dcache_ctrl #(.CACHESIZE(CS), .INDEX(INDEX), .TAG(TAG)) dut (
    .Clk(Clk), .Reset(Reset),
    .CpuReq(CpuReq), .CpuWr(CpuWr), .CpuAddr(CpuAddr), .CpuWData(CpuWData),
    .CpuRData(CpuRData), .CpuReady(CpuReady), .Busy(Busy), .RamAddr(RamAddr),
    .TagWr(TagWr), .TagIn(TagIn), .TagOut(TagOut),
    .ValidWr(ValidWr), .ValidIn(ValidIn), .ValidOut(ValidOut),
    .DataWr(DataWr), .DataIn(DataIn), .DataOut(DataOut), .RamInv(RamInv),
    .MemReq(MemReq), .MemWr(MemWr), .MemAddr(MemAddr), .MemWData(MemWData),
    .MemRData(MemRData), .MemAck(MemAck)
  );

  always #5 Clk = ~Clk;

  int tests = 0;
  int fails = 0;

  // Cache RAMs with registered read ports; RamInv clears tag and valid.
  logic [TAG-1:0] tag_ram [CS];
  logic           valid_ram [CS];
  logic [7:0]     data_ram [CS];

  int n_tagwr = 0, n_validwr = 0, n_datawr = 0, n_memrd = 0, n_memwr = 0;
  int n_conflict = 0, n_unstable = 0;
  logic [TAG-1:0]   last_tag = '0;
  logic [INDEX-1:0] last_tag_idx = '0;
  logic [ADDR-1:0]  last_waddr = '0;
  logic [7:0]       last_wdata = '0;
  logic             req_pend = 1'b0;
  logic [ADDR+8:0]  held = '0;

  always @(posedge Clk) begin
    if (RamInv) begin
      for (int i = 0; i < CS; i++) begin
        valid_ram[i] <= 1'b0;
        tag_ram[i]   <= '0;
      end
    end else begin
      if (TagWr)   tag_ram[RamAddr]   <= TagIn;
      if (ValidWr) valid_ram[RamAddr] <= ValidIn;
    end
    if (DataWr) data_ram[RamAddr] <= DataIn;
    TagOut   <= tag_ram[RamAddr];
    ValidOut <= valid_ram[RamAddr];
    DataOut  <= data_ram[RamAddr];

    if (TagWr) begin
      n_tagwr      <= n_tagwr + 1;
      last_tag     <= TagIn;
      last_tag_idx <= RamAddr;
    end
    if (ValidWr) n_validwr <= n_validwr + 1;
    if (DataWr)  n_datawr  <= n_datawr + 1;
    if ((TagWr || ValidWr || DataWr) && RamInv) n_conflict <= n_conflict + 1;
    if (MemReq && MemAck && !MemWr) n_memrd <= n_memrd + 1;
    if (MemReq && MemAck && MemWr) begin
      n_memwr    <= n_memwr + 1;
      last_waddr <= MemAddr;
      last_wdata <= MemWData;
    end
    if (MemReq && req_pend && ({MemWr, MemAddr, MemWData} != held)) n_unstable <= n_unstable + 1;
    req_pend <= MemReq && !MemAck;
    held     <= {MemWr, MemAddr, MemWData};
  end

  // Backing memory and the reference model's view of it.
  logic [7:0] mem     [65536];
  logic [7:0] ref_mem [65536];
  bit         ref_valid [CS];
  logic [TAG-1:0] ref_tag [CS];

  int ack_delay = 1;   // cycles MemReq stays high, including the acknowledge cycle
  bit mem_hold  = 1'b0;
  int stray_tok = 0;

  initial begin
    int cnt = 0;
    int stray_seen = 0;
    MemAck = 1'b0;
    MemRData = 8'h00;
    forever begin
      @(negedge Clk);
      if (MemAck) begin
        MemAck = 1'b0;
      end else if (stray_tok != stray_seen) begin
        stray_seen = stray_tok;
        MemAck = 1'b1;
        MemRData = 8'hEE;
      end else if (MemReq && !mem_hold) begin
        if (cnt >= ack_delay - 1) begin
          MemAck = 1'b1;
          MemRData = mem[MemAddr];
          if (MemWr) mem[MemAddr] = MemWData;
          cnt = 0;
        end else begin
          cnt++;
        end
      end else if (!MemReq) begin
        cnt = 0;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    @(negedge Clk);
    while (Busy && n < 200) begin
      @(negedge Clk);
      n++;
    end
    check("idle_timeout", {31'd0, Busy}, 32'd0);
  endtask

  task automatic do_op(input bit wr, input logic [ADDR-1:0] a, input logic [7:0] d, input int n);
    logic [INDEX-1:0] idx;
    logic [TAG-1:0]   tg;
    bit   hit, got;
    int   lat, exp_lat;
    int   tw0, vw0, dw0, mr0, mw0;
    logic [7:0] rd0;
    wait_idle();
    idx = a[INDEX-1:0];
    tg  = a[ADDR-1:INDEX];
    hit = ref_valid[idx] && (ref_tag[idx] == tg);
    tw0 = n_tagwr; vw0 = n_validwr; dw0 = n_datawr; mr0 = n_memrd; mw0 = n_memwr;
    rd0 = CpuRData;
    ack_delay = n;
    CpuReq = 1'b1; CpuWr = wr; CpuAddr = a; CpuWData = d;
    @(posedge Clk);
    #1 CpuReq = 1'b0;
    lat = 0; got = 1'b0;
    while (!got && lat < 200) begin
      @(negedge Clk);
      lat++;
      if (CpuReady) got = 1'b1;
    end
    check("ready_timeout", {31'd0, got}, 32'd1);
    if (!wr) begin
      exp_lat = hit ? 2 : n + 3;
      check("load_latency", lat, exp_lat);
      check("load_data", {24'd0, CpuRData}, {24'd0, ref_mem[a]});
      check("load_memrd", n_memrd - mr0, hit ? 0 : 1);
      check("load_tagwr", n_tagwr - tw0, hit ? 0 : 1);
      check("load_validwr", n_validwr - vw0, hit ? 0 : 1);
      if (!hit) begin
        check("fill_tag", {26'd0, last_tag}, {26'd0, tg});
        check("fill_index", {22'd0, last_tag_idx}, {22'd0, idx});
        ref_valid[idx] = 1'b1;
        ref_tag[idx]   = tg;
      end
    end else begin
      exp_lat = n + 2;
      check("store_latency", lat, exp_lat);
      check("store_memwr", n_memwr - mw0, 1);
      check("store_waddr", {16'd0, last_waddr}, {16'd0, a});
      check("store_wdata", {24'd0, last_wdata}, {24'd0, d});
      check("store_tagwr", n_tagwr - tw0, 0);
      check("store_validwr", n_validwr - vw0, 0);
      check("store_datawr", n_datawr - dw0, hit ? 1 : 0);
      check("store_memrd", n_memrd - mr0, 0);
      check("store_rdata_kept", {24'd0, CpuRData}, {24'd0, rd0});
      ref_mem[a] = d;
    end
    @(negedge Clk);
    check("ready_single_pulse", {31'd0, CpuReady}, 32'd0);
  endtask

  initial begin
    int k, inv_cnt, tw0, vw0, dw0, mr0;
    logic [INDEX-1:0] pool [8];
    Reset = 1'b1; CpuReq = 1'b0; CpuWr = 1'b0; CpuAddr = '0; CpuWData = '0;
    for (int i = 0; i < 65536; i++) begin
      mem[i] = 8'($urandom);
      ref_mem[i] = mem[i];
    end
    for (int i = 0; i < CS; i++) begin
      ref_valid[i] = 1'b0;
      ref_tag[i] = '0;
    end
    mem[16'h0123] = 8'h5A; ref_mem[16'h0123] = 8'h5A;

    // Reset state
    repeat (3) @(posedge Clk);
    @(negedge Clk);
    check("rst_ready", {31'd0, CpuReady}, 32'd0);
    check("rst_rdata", {24'd0, CpuRData}, 32'd0);
    check("rst_memreq", {31'd0, MemReq}, 32'd0);
    check("rst_busy", {31'd0, Busy}, 32'd1);
    check("rst_strobes", {29'd0, TagWr, ValidWr, DataWr}, 32'd0);
    Reset = 1'b0;
    #1;
    check("init_raminv", {31'd0, RamInv}, 32'd1);
    check("init_busy", {31'd0, Busy}, 32'd1);
    @(negedge Clk);
    check("idle_raminv", {31'd0, RamInv}, 32'd0);
    check("idle_busy", {31'd0, Busy}, 32'd0);

    // Directed sequence
    do_op(1'b0, 16'h0123, 8'h00, 3);   // miss, fill 0x5A
    do_op(1'b0, 16'h0123, 8'h00, 1);   // hit
    do_op(1'b1, 16'h0123, 8'hC3, 2);   // store hit
    do_op(1'b0, 16'h0123, 8'h00, 1);   // hit, returns C3
    do_op(1'b1, 16'h0523, 8'h77, 1);   // store miss, no allocate
    do_op(1'b0, 16'h0123, 8'h00, 1);   // still hits
    do_op(1'b0, 16'h0523, 8'h00, 2);   // miss, evicts tag 0
    do_op(1'b0, 16'h0123, 8'h00, 1);   // miss again

    // Reset in the middle of a read miss
    wait_idle();
    mem_hold = 1'b1;
    tw0 = n_tagwr; vw0 = n_validwr; dw0 = n_datawr; mr0 = n_memrd;
    CpuReq = 1'b1; CpuWr = 1'b0; CpuAddr = 16'h0523;
    @(posedge Clk);
    #1 CpuReq = 1'b0;
    k = 0;
    do begin
      @(negedge Clk);
      k++;
    end while (!MemReq && k < 20);
    check("mid_miss_memreq", {31'd0, MemReq}, 32'd1);
    Reset = 1'b1;
    @(posedge Clk);
    @(negedge Clk);
    check("rst_drops_memreq", {31'd0, MemReq}, 32'd0);
    check("rst_busy2", {31'd0, Busy}, 32'd1);
    Reset = 1'b0;
    mem_hold = 1'b0;
    #1;
    inv_cnt = RamInv ? 1 : 0;
    repeat (4) begin
      @(negedge Clk);
      #1;
      if (RamInv) inv_cnt++;
    end
    check("raminv_pulses", inv_cnt, 1);
    check("rst_no_tagwr", n_tagwr - tw0, 0);
    check("rst_no_validwr", n_validwr - vw0, 0);
    check("rst_no_datawr", n_datawr - dw0, 0);
    for (int i = 0; i < CS; i++) ref_valid[i] = 1'b0;
    stray_tok++;
    k = 0;
    repeat (4) begin
      @(negedge Clk);
      if (CpuReady || Busy) k++;
    end
    check("stray_ack_ignored", k, 0);
    check("stray_no_memrd", n_memrd - mr0, 0);
    do_op(1'b0, 16'h0523, 8'h00, 2);   // misses after invalidate
    do_op(1'b0, 16'h0523, 8'h00, 1);   // then hits

    // Random traffic over a small set of indices to mix hits, misses and evictions
    pool[0] = 10'h123; pool[1] = 10'h000; pool[2] = 10'h3FF; pool[3] = 10'h055;
    for (int i = 4; i < 8; i++) pool[i] = INDEX'($urandom);
    for (int i = 0; i < 80; i++) begin
      logic [ADDR-1:0] a;
      a = {TAG'($urandom_range(0, 3)), pool[$urandom_range(0, 7)]};
      do_op(1'($urandom_range(0, 2) == 0), a, 8'($urandom), $urandom_range(1, 4));
    end

    check("no_strobe_inv_overlap", n_conflict, 0);
    check("memreq_fields_stable", n_unstable, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
